// File: rtl/eth_phy_10g_rx_err_inj.sv
// Sync-header / payload error injector between the SERDES RX and the 10GBASE-R PCS RX.
// Corrupts selected 66-bit blocks in one-shot or periodic bursts and counts each corrupted block.
module eth_phy_10g_rx_err_inj #(
  parameter int DATA_WIDTH = 64,
  parameter int HDR_WIDTH  = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rx_clk,
  input  logic                  rx_rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [HDR_WIDTH-1:0]  in_hdr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [HDR_WIDTH-1:0]  out_hdr,
  output logic                  out_err,
  input  logic                  cfg_periodic,
  input  logic                  cfg_hdr_sel,
  input  logic [DATA_WIDTH-1:0] cfg_data_mask,
  input  logic [CNT_WIDTH-1:0]  cfg_gap,
  input  logic [CNT_WIDTH-1:0]  cfg_burst_len,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  cnt_clr,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  inj_count
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;

  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  state_t                state, state_nxt;
  logic [CNT_WIDTH-1:0]  cnt, cnt_nxt;
  logic                  done_nxt;
  logic                  periodic_q, hdr_sel_q;
  logic [DATA_WIDTH-1:0] mask_q;
  logic [CNT_WIDTH-1:0]  gap_q, len_q;
  logic                  accept, corrupt;
  logic [HDR_WIDTH-1:0]  hdr_bad;

  assign accept  = (state == S_IDLE) && start && !stop;
  // The block sampled alongside stop always passes through untouched.
  assign corrupt = (state == S_BURST) && !stop;
  assign busy    = (state != S_IDLE);
  // cnt restarts at 0 on every burst, so its LSB gives the ones/zeros alternation.
  assign hdr_bad = hdr_sel_q ? ~in_hdr : (cnt[0] ? '0 : '1);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    if (stop) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            // Config is latched on this same edge, so decide from the live input.
            state_nxt = (cfg_gap == '0) ? S_BURST : S_WAIT;
            cnt_nxt   = '0;
          end
        end
        S_WAIT: begin
          if (cnt == gap_q - ONE) begin
            state_nxt = S_BURST;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + ONE;
          end
        end
        S_BURST: begin
          if (cnt == len_q - ONE) begin
            cnt_nxt = '0;
            if (periodic_q) begin
              state_nxt = (gap_q == '0) ? S_BURST : S_WAIT;
            end else begin
              state_nxt = S_IDLE;
              done_nxt  = 1'b1;
            end
          end else begin
            cnt_nxt = cnt + ONE;
          end
        end
        default: begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge rx_clk or negedge rx_rst) begin
    if (!rx_rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      done  <= done_nxt;
    end
  end

  always_ff @(posedge rx_clk or negedge rx_rst) begin
    if (!rx_rst) begin
      periodic_q <= 1'b0;
      hdr_sel_q  <= 1'b0;
      mask_q     <= '0;
      gap_q      <= '0;
      len_q      <= '0;
    end else if (accept) begin
      periodic_q <= cfg_periodic;
      hdr_sel_q  <= cfg_hdr_sel;
      mask_q     <= cfg_data_mask;
      gap_q      <= cfg_gap;
      len_q      <= (cfg_burst_len == '0) ? ONE : cfg_burst_len;
    end
  end

  always_ff @(posedge rx_clk or negedge rx_rst) begin
    if (!rx_rst) begin
      out_data <= '0;
      out_hdr  <= '0;
      out_err  <= 1'b0;
    end else begin
      out_data <= corrupt ? (in_data ^ mask_q) : in_data;
      out_hdr  <= corrupt ? hdr_bad : in_hdr;
      out_err  <= corrupt;
    end
  end

  always_ff @(posedge rx_clk or negedge rx_rst) begin
    if (!rx_rst)
      inj_count <= '0;
    else if (cnt_clr)
      inj_count <= '0;
    else if (corrupt && (inj_count != '1))
      inj_count <= inj_count + ONE;
  end

endmodule
